// File: rtl/i2s_tx.sv
// Stereo I2S / left-justified transmitter with a one-deep valid/ready holding register.
// On underrun the previous frame is repeated and a one-clock underrun pulse is raised.
module i2s_tx #(
  parameter int unsigned DW   = 16,
  parameter int unsigned SLOT = 16,
  parameter int unsigned DIV  = 16,
  parameter int unsigned MODE = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] l,
  input  logic [DW-1:0] r,
  input  logic          valid,
  output logic          ready,
  output logic [2:0]    i2s,
  output logic          underrun
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW = $clog2(2 * SLOT);

  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(2 * SLOT - 1);
  localparam logic [PW-1:0] P_SLOT = PW'(SLOT);
  localparam logic [PW-1:0] P_DW   = PW'(DW);

  logic [CW-1:0] c;
  logic          bck;
  logic          lrck;
  logic          sd;
  logic          full;
  logic [PW-1:0] p;
  logic [DW-1:0] frame_l, frame_r;
  logic [DW-1:0] hold_l, hold_r;

  logic          tick, fall, frame_start;
  logic [PW-1:0] p_next, p_lead, k;
  logic [DW-1:0] next_l, next_r, word, shifted;
  logic          ch, sd_next, lrck_next;

  always_comb begin
    tick        = (c == C_LAST);
    fall        = tick & bck;
    frame_start = fall & (p == P_LAST);
    p_next      = (p == P_LAST) ? '0 : p + 1'b1;
    p_lead      = (p_next == P_LAST) ? '0 : p_next + 1'b1;

    next_l = frame_l;
    next_r = frame_r;
    if (frame_start) begin
      if (full) begin
        next_l = hold_l;
        next_r = hold_r;
      end else if (valid) begin
        next_l = l;
        next_r = r;
      end
    end

    // Output bits are derived from the position being entered, so that the
    // frame-start fall already shows the MSB of the freshly loaded frame.
    ch        = (p_next >= P_SLOT);
    k         = ch ? p_next - P_SLOT : p_next;
    word      = ch ? next_r : next_l;
    shifted   = word << k;
    sd_next   = (k < P_DW) ? shifted[DW-1] : 1'b0;
    lrck_next = (MODE == 1) ? ch : (p_lead >= P_SLOT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c        <= '0;
      bck      <= 1'b0;
      p        <= '0;
      sd       <= 1'b0;
      lrck     <= 1'b0;
      frame_l  <= '0;
      frame_r  <= '0;
      hold_l   <= '0;
      hold_r   <= '0;
      full     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (tick) begin
        c   <= '0;
        bck <= ~bck;
      end else begin
        c <= c + 1'b1;
      end

      if (fall) begin
        p    <= p_next;
        sd   <= sd_next;
        lrck <= lrck_next;
      end

      frame_l  <= next_l;
      frame_r  <= next_r;
      underrun <= frame_start & ~full & ~valid;

      // A bypass load at frame start consumes the pair directly into the frame.
      if (frame_start && full) begin
        full <= 1'b0;
      end else if (valid && !full && !frame_start) begin
        hold_l <= l;
        hold_r <= r;
        full   <= 1'b1;
      end
    end
  end

  assign ready = ~full;
  assign i2s   = {sd, lrck, bck};

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: default Philips instance and a left-justified DW=16/SLOT=24 instance.
module tb_i2s_tx;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, valid_a, ready_a, underrun_a;
  logic [15:0] l_a, r_a;
  logic [2:0]  i2s_a;

  logic        reset_b, valid_b, ready_b, underrun_b;
  logic [15:0] l_b, r_b;
  logic [2:0]  i2s_b;

  i2s_tx dut_a (
    .clock(clock), .reset(reset_a), .l(l_a), .r(r_a), .valid(valid_a),
    .ready(ready_a), .i2s(i2s_a), .underrun(underrun_a)
  );

  i2s_tx #(.DW(16), .SLOT(24), .DIV(2), .MODE(1)) dut_b (
    .clock(clock), .reset(reset_b), .l(l_b), .r(r_b), .valid(valid_b),
    .ready(ready_b), .i2s(i2s_b), .underrun(underrun_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned ucnt     = 0;
  logic [15:0] n_acc    = '0;
  logic        stream   = 1'b0;
  logic [63:0] sdv, lrv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic step(input int unsigned n);
    logic acc;
    for (int unsigned i = 0; i < n; i++) begin
      acc = stream && valid_a && ready_a;
      @(posedge clock);
      #1;
      cyc++;
      if (underrun_a) ucnt++;
      if (acc) begin
        n_acc++;
        l_a = 16'hA000 + n_acc;
        r_a = 16'h5000 + n_acc;
      end
    end
  endtask

  task automatic goto(input int unsigned target);
    step(target - cyc);
  endtask

  task automatic capture(input bit sel, input int unsigned n, input int unsigned div,
                         output logic [63:0] sd_bits, output logic [63:0] lr_bits);
    sd_bits = '0;
    lr_bits = '0;
    for (int unsigned j = 0; j < n; j++) begin
      if (j > 0) step(2 * div);
      sd_bits = {sd_bits[62:0], sel ? i2s_b[2] : i2s_a[2]};
      lr_bits = {lr_bits[62:0], sel ? i2s_b[1] : i2s_a[1]};
    end
    step(2 * div);
  endtask

  initial begin
    reset_a = 1'b1; valid_a = 1'b0; l_a = '0; r_a = '0;
    reset_b = 1'b1; valid_b = 1'b0; l_b = '0; r_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_i2s", 64'(i2s_a), 64'h0);
    check("reset_ready", 64'(ready_a), 64'h1);
    reset_a = 1'b0;
    cyc = 0;

    step(15); check("bck_before_rise", 64'(i2s_a[0]), 64'h0);
    step(1);  check("bck_rise_16", 64'(i2s_a[0]), 64'h1);
    step(15); check("bck_before_fall", 64'(i2s_a[0]), 64'h1);
    step(1);  check("bck_fall_32", 64'(i2s_a[0]), 64'h0);

    goto(40);
    valid_a = 1'b1; l_a = 16'h8001; r_a = 16'h7FFE;
    step(1);
    check("ready_after_accept", 64'(ready_a), 64'h0);
    valid_a = 1'b0;

    goto(1024);
    check("ready_after_consume", 64'(ready_a), 64'h1);
    check("no_underrun_first", 64'(underrun_a), 64'h0);
    ucnt = 0;
    capture(1'b0, 32, 16, sdv, lrv);
    check("sd_frame1", sdv, 64'h80017FFE);
    check("lrck_mode0", lrv, 64'h0001FFFE);
    check("underrun_pulse", 64'(underrun_a), 64'h1);
    check("underrun_count1", 64'(ucnt), 64'h1);

    ucnt = 0;
    capture(1'b0, 32, 16, sdv, lrv);
    check("sd_repeat", sdv, 64'h80017FFE);
    check("underrun_count2", 64'(ucnt), 64'h1);

    ucnt = 0;
    n_acc = '0; l_a = 16'hA000; r_a = 16'h5000;
    valid_a = 1'b1; stream = 1'b1;
    step(1);
    check("bp_ready_drop", 64'(ready_a), 64'h0);
    check("bp_one_accept", 64'(n_acc), 64'h1);
    goto(4096);
    check("bp_no_underrun_wait", 64'(ucnt), 64'h0);
    capture(1'b0, 32, 16, sdv, lrv);
    check("bp_pair0", sdv, 64'hA0005000);
    capture(1'b0, 32, 16, sdv, lrv);
    check("bp_pair1", sdv, 64'hA0015001);
    capture(1'b0, 32, 16, sdv, lrv);
    check("bp_pair2", sdv, 64'hA0025002);
    check("bp_accept_count", 64'(n_acc), 64'h4);
    check("bp_no_underrun", 64'(ucnt), 64'h0);

    goto(7808 + 5);
    check("full_before_reset", 64'(ready_a), 64'h0);
    stream = 1'b0; valid_a = 1'b0; reset_a = 1'b1;
    step(1);
    check("midreset_i2s", 64'(i2s_a), 64'h0);
    check("midreset_ready", 64'(ready_a), 64'h1);
    reset_a = 1'b0;
    cyc = 0; ucnt = 0;
    goto(1024);
    check("post_reset_underrun", 64'(underrun_a), 64'h1);
    capture(1'b0, 32, 16, sdv, lrv);
    check("post_reset_sd_zero", sdv, 64'h0);
    check("post_reset_lrck", lrv, 64'h0001FFFE);

    reset_b = 1'b0;
    cyc = 0;
    goto(5);
    valid_b = 1'b1; l_b = 16'hFFFF; r_b = 16'h0000;
    step(1);
    check("b_ready_drop", 64'(ready_b), 64'h0);
    valid_b = 1'b0;
    goto(192);
    check("b_no_underrun", 64'(underrun_b), 64'h0);
    capture(1'b1, 48, 2, sdv, lrv);
    check("b_sd_lj_pad", sdv, 64'h0000FFFF00000000);
    check("b_lrck_lj", lrv, 64'h0000000000FFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
